icache_refill_ctrl: RTL and testbench

//  Memory-side refill engine for the instruction cache set.
//  - Accepts a miss address and fetches the full cacheline one word at a time over a req/gnt/rvalid memory port.
//  - Assembles the words into a line buffer and presents the line to the cache set with a one-hot replace vector.
//  - Selects the victim line round-robin.

---
 rtl/icache_refill_ctrl.sv | 125 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_ctrl
// Purpose  : Memory-side refill engine for one instruction-cache set. Takes a
//            miss address, reads the whole cacheline one word at a time over
//            a req/gnt/rvalid port, assembles it in a line buffer and hands it
//            to the set with a one-hot, round-robin victim select.
// Ports    : clk, reset_i                      clock, sync active-high reset
//            miss_valid_i/miss_addr_i/miss_ready_o   miss request handshake
//            mem_req_o/mem_addr_o/mem_gnt_i          memory read request
//            mem_rvalid_i/mem_rdata_i                memory read data
//            fill_valid_o/fill_addr_o/fill_data_o    completed line to the set
//            replace_o                               one-hot victim select
// Revision : 1.0  initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int N_CACHELINE_LENGTH = 4,
    parameter int N_CACHELINES       = 8,
    parameter int BITSIZE            = 32
) (
    input  logic                              clk,
    input  logic                              reset_i,
    input  logic                              miss_valid_i,
    input  logic [31:0]                       miss_addr_i,
    output logic                              miss_ready_o,
    output logic                              mem_req_o,
    output logic [31:0]                       mem_addr_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rvalid_i,
    input  logic [BITSIZE-1:0]                mem_rdata_i,
    output logic                              fill_valid_o,
    output logic [31:0]                       fill_addr_o,
    output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] fill_data_o,
    output logic [N_CACHELINES-1:0]           replace_o
);

    // Byte-offset bits inside a line; word index occupies [c_OFS-1:2].
    localparam int c_CW  = $clog2(N_CACHELINE_LENGTH);
    localparam int c_OFS = c_CW + 2;
    localparam int c_VW  = (N_CACHELINES > 1) ? $clog2(N_CACHELINES) : 1;

    localparam logic [c_CW-1:0] c_LAST_WORD   = c_CW'(N_CACHELINE_LENGTH - 1);
    localparam logic [c_VW-1:0] c_LAST_VICTIM = c_VW'(N_CACHELINES - 1);
    localparam logic [N_CACHELINES-1:0] c_ONE_HOT0 = N_CACHELINES'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_FILL = 2'd3;

    logic [1:0]                          r_state;
    logic [31:c_OFS]                     r_tag;       // line address of refill in flight
    logic [31:c_OFS]                     r_fill_tag;  // line address of last completed line
    logic [c_CW-1:0]                     r_cnt;
    logic [c_VW-1:0]                     r_victim;
    logic [BITSIZE*N_CACHELINE_LENGTH-1:0] r_line;

    // Offset bits of the miss address are deliberately dropped.
    logic w_unused_offset;
    assign w_unused_offset = &{1'b0, miss_addr_i[c_OFS-1:0]};

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state    <= c_ST_IDLE;
            r_tag      <= '0;
            r_fill_tag <= '0;
            r_cnt      <= '0;
            r_victim   <= '0;
            r_line     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (miss_valid_i) begin
                        r_tag   <= miss_addr_i[31:c_OFS];
                        r_cnt   <= '0;
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    // Request and address stay up until the memory grants.
                    if (mem_gnt_i) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        for (int k = 0; k < N_CACHELINE_LENGTH; k++) begin
                            if (r_cnt == c_CW'(k)) begin
                                r_line[k*BITSIZE +: BITSIZE] <= mem_rdata_i;
                            end
                        end
                        if (r_cnt == c_LAST_WORD) begin
                            r_fill_tag <= r_tag;
                            r_state    <= c_ST_FILL;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= c_ST_REQ;
                        end
                    end
                end
                c_ST_FILL: begin
                    // Victim advances after it has been presented this cycle.
                    if (r_victim == c_LAST_VICTIM) begin
                        r_victim <= '0;
                    end else begin
                        r_victim <= r_victim + 1'b1;
                    end
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Moore outputs, decoded only from registered state.
    assign miss_ready_o = (r_state == c_ST_IDLE);
    assign mem_req_o    = (r_state == c_ST_REQ);
    assign mem_addr_o   = (r_state == c_ST_REQ) ? {r_tag, r_cnt, 2'b00} : 32'd0;
    assign fill_valid_o = (r_state == c_ST_FILL);
    assign fill_addr_o  = {r_fill_tag, {c_OFS{1'b0}}};
    assign fill_data_o  = r_line;
    assign replace_o    = (r_state == c_ST_FILL) ? (c_ONE_HOT0 << r_victim) : '0;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_refill_ctrl
// Purpose  : Directed, table-driven bench for icache_refill_ctrl. Each table
//            record describes one refill (miss address, data seed, grant
//            stall, spurious rvalid, intruding miss) with its expected line
//            address and victim; the reset-during-refill case is hand-written.
// Revision : 1.0  initial release
// ============================================================================
module tb_icache_refill_ctrl;

    localparam int NW = 4;
    localparam int NL = 8;
    localparam int BW = 32;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            miss_valid_i = 1'b0;
    logic [31:0]     miss_addr_i = '0;
    logic            miss_ready_o;
    logic            mem_req_o;
    logic [31:0]     mem_addr_o;
    logic            mem_gnt_i = 1'b0;
    logic            mem_rvalid_i = 1'b0;
    logic [BW-1:0]   mem_rdata_i = '0;
    logic            fill_valid_o;
    logic [31:0]     fill_addr_o;
    logic [BW*NW-1:0] fill_data_o;
    logic [NL-1:0]   replace_o;

    always #5 clk = ~clk;

    icache_refill_ctrl #(
        .N_CACHELINE_LENGTH(NW),
        .N_CACHELINES      (NL),
        .BITSIZE           (BW)
    ) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .miss_valid_i(miss_valid_i),
        .miss_addr_i (miss_addr_i),
        .miss_ready_o(miss_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .fill_valid_o(fill_valid_o),
        .fill_addr_o (fill_addr_o),
        .fill_data_o (fill_data_o),
        .replace_o   (replace_o)
    );

    typedef struct {
        logic [31:0] addr;       // miss address driven
        logic [31:0] seed;       // word k of the line = seed + k
        int          dly_word;   // word whose grant is stalled (-1: none)
        int          dly;        // stall cycles before the grant
        bit          spur;       // drive rvalid with junk outside WAIT
        bit          intrude;    // drive a new miss during WAIT/FILL
        logic [31:0] intr_addr;  // address of that intruding miss
        logic [31:0] exp_base;   // expected line base address
        logic [7:0]  exp_repl;   // expected one-hot victim
    } vec_t;

    vec_t        vecs [10];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_fill_addr = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [BW*NW-1:0] exp_data;
        logic [31:0]      exp_addr;
        logic [31:0]      word;
        int               nd;
        // Accept cycle (IDLE); previous line must still be on the fill port.
        miss_valid_i = 1'b1;
        miss_addr_i  = v.addr;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = v.spur;
        mem_rdata_i  = 32'hDEAD_0000;
        @(negedge clk);
        chk("idle_ready", miss_ready_o, 1);
        chk("idle_req", mem_req_o, 0);
        chk("idle_addr", mem_addr_o, 0);
        chk("idle_fill_valid", fill_valid_o, 0);
        chk("idle_replace", replace_o, 0);
        chk("hold_fill_addr", fill_addr_o, last_fill_addr);
        step();
        for (int k = 0; k < NW; k++) begin
            nd = (k == v.dly_word) ? v.dly : 0;
            for (int d = 0; d <= nd; d++) begin
                miss_valid_i = 1'b0;
                mem_gnt_i    = (d == nd);
                mem_rvalid_i = v.spur;
                mem_rdata_i  = 32'hBAD0_0000 | k;
                exp_addr     = v.exp_base + 32'(4 * k);
                @(negedge clk);
                chk("req", mem_req_o, 1);
                chk("req_addr", mem_addr_o, exp_addr);
                chk("req_ready", miss_ready_o, 0);
                step();
            end
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = v.seed + 32'(k);
            miss_valid_i = v.intrude;
            miss_addr_i  = v.intr_addr;
            @(negedge clk);
            chk("wait_req", mem_req_o, 0);
            chk("wait_addr", mem_addr_o, 0);
            chk("wait_fill_valid", fill_valid_o, 0);
            chk("wait_ready", miss_ready_o, 0);
            step();
        end
        // FILL cycle
        mem_rvalid_i = v.spur;
        mem_rdata_i  = 32'hFFFF_0000;
        miss_valid_i = v.intrude;
        for (int k = 0; k < NW; k++) begin
            word = v.seed + 32'(k);
            exp_data[k*BW +: BW] = word;
        end
        @(negedge clk);
        chk("fill_valid", fill_valid_o, 1);
        chk("fill_addr", fill_addr_o, v.exp_base);
        chk("fill_data", fill_data_o, exp_data);
        chk("replace", replace_o, v.exp_repl);
        chk("fill_ready", miss_ready_o, 0);
        chk("fill_req", mem_req_o, 0);
        last_fill_addr = v.exp_base;
        step();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        //            addr          seed          dw  dly spur intr intr_addr     base          repl
        vecs[0] = '{32'h0000_1234, 32'h0000_00A0, -1, 0, 1'b0, 1'b0, 32'h0,        32'h0000_1230, 8'h01};
        vecs[1] = '{32'h0000_ABCF, 32'h1111_0000, -1, 0, 1'b1, 1'b0, 32'h0,        32'h0000_ABC0, 8'h02};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, 0, 1'b0, 1'b0, 32'h0,        32'hFFFF_FFF0, 8'h04};
        vecs[3] = '{32'h8000_0008, 32'h5555_0000,  2, 3, 1'b1, 1'b0, 32'h0,        32'h8000_0000, 8'h08};
        vecs[4] = '{32'h0000_2000, 32'h2000_0000, -1, 0, 1'b0, 1'b1, 32'h0000_3004, 32'h0000_2000, 8'h10};
        vecs[5] = '{32'h0000_3004, 32'h3000_0000, -1, 0, 1'b0, 1'b0, 32'h0,        32'h0000_3000, 8'h20};
        vecs[6] = '{32'h1234_5670, 32'hC0DE_0000,  0, 1, 1'b1, 1'b0, 32'h0,        32'h1234_5670, 8'h40};
        vecs[7] = '{32'h0000_001C, 32'h0000_0007, -1, 0, 1'b0, 1'b0, 32'h0,        32'h0000_0010, 8'h80};
        vecs[8] = '{32'h0000_0000, 32'h0BAD_F00D, -1, 0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 8'h01};
        vecs[9] = '{32'h7FFF_FFF4, 32'h1234_5678,  3, 2, 1'b1, 1'b0, 32'h0,        32'h7FFF_FFF0, 8'h02};

        // Reset and reset-value checks
        reset_i = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_ready", miss_ready_o, 1);
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_fill_valid", fill_valid_o, 0);
        chk("rst_replace", replace_o, 0);
        chk("rst_fill_data", fill_data_o, 0);
        chk("rst_fill_addr", fill_addr_o, 0);
        step();
        reset_i = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset after word 1 returned: partial line discarded, victim cleared.
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h0000_4008;
        step();
        miss_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b0;
            step();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hD000_0000 | k;
            step();
        end
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", mem_req_o, 1);
        chk("pre_rst_addr", mem_addr_o, 32'h0000_4008);
        reset_i   = 1'b1;
        mem_gnt_i = 1'b1;
        step();
        reset_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBBBB_BBBB;
        @(negedge clk);
        chk("mid_rst_ready", miss_ready_o, 1);
        chk("mid_rst_req", mem_req_o, 0);
        chk("mid_rst_addr", mem_addr_o, 0);
        chk("mid_rst_fill_valid", fill_valid_o, 0);
        chk("mid_rst_replace", replace_o, 0);
        chk("mid_rst_fill_data", fill_data_o, 0);
        chk("mid_rst_fill_addr", fill_addr_o, 0);
        step();
        @(negedge clk);
        chk("stale_rvalid_data", fill_data_o, 0);
        chk("stale_rvalid_ready", miss_ready_o, 1);
        step();
        mem_rvalid_i   = 1'b0;
        last_fill_addr = 32'h0;
        rv = '{32'h0000_5004, 32'h0000_5000, -1, 0, 1'b1, 1'b0, 32'h0, 32'h0000_5000, 8'h01};
        run_vec(rv);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
